bus_req_arbiter: RTL and testbench

BUS_REQ_ARBITER -- requirements
Module: bus_req_arbiter

---
 rtl/bus_pkg.sv | 36 +++
 rtl/bus_split_calc.sv | 37 +++
 rtl/bus_req_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_req_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus definitions: widths, size codes, arbiter states, size helpers
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // Bus size codes: a byte count of 1..3 is its own code, 4 bytes wraps to 00.
    localparam logic [1:0] SZ_4 = 2'b00;
    localparam logic [1:0] SZ_1 = 2'b01;
    localparam logic [1:0] SZ_2 = 2'b10;
    localparam logic [1:0] SZ_3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        DONE   = 3'd5
    } arb_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return (size == SZ_4) ? 3'd4 : {1'b0, size};
    endfunction

    // Right-justified mask covering n bytes (n = 1..4).
    function automatic logic [BUS_DW-1:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            3'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/bus_split_calc.sv
// rtl/bus_split_calc.sv - combinational size/split arithmetic for one requester transfer
// Ports: addr/size in (request); split, size1 (first cycle), addr2/size2 (second cycle),
//        shift2 (merge shift in bits), mask_n (whole request), mask_n2 (second cycle) out.
module bus_split_calc
    import bus_pkg::*;
(
    input  logic [BUS_AW-1:0] addr,
    input  logic [1:0]        size,
    output logic              split,
    output logic [1:0]        size1,
    output logic [BUS_AW-1:0] addr2,
    output logic [1:0]        size2,
    output logic [4:0]        shift2,
    output logic [BUS_DW-1:0] mask_n,
    output logic [BUS_DW-1:0] mask_n2
);

    logic [2:0] n;
    logic [2:0] sum;
    logic [1:0] n2;

    always_comb begin
        n     = size_bytes(size);
        sum   = {1'b0, addr[1:0]} + n;
        split = (sum > 3'd4);
        // When split, sum is 5..7 so the bytes left over for the next word are sum[1:0].
        n2    = split ? sum[1:0] : 2'd0;
        // First cycle carries 4 - offset bytes; modulo 4 that is simply -offset.
        size1 = split ? (2'd0 - addr[1:0]) : size;
        size2 = n2;
        addr2 = {addr[BUS_AW-1:2], 2'b00} + 32'd4;
        shift2  = {n2, 3'b000};
        mask_n  = byte_mask(n);
        mask_n2 = byte_mask({1'b0, n2});
    end

endmodule

// File: rtl/bus_req_arbiter.sv
// rtl/bus_req_arbiter.sv - data/fetch requester arbiter that splits word-crossing transfers
// Ports: CLK, nRESET; data requester DReq/DAddr/DSize/DAck; fetch requester FReq/FAddr/FSize/FAck;
//        RData merged result; bus side BReq/AddrReq/SizeReq out, BReqComplete/BData in.
module bus_req_arbiter
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              DReq,
    input  logic [BUS_AW-1:0] DAddr,
    input  logic [1:0]        DSize,
    output logic              DAck,
    input  logic              FReq,
    input  logic [BUS_AW-1:0] FAddr,
    input  logic [1:0]        FSize,
    output logic              FAck,
    output logic [BUS_DW-1:0] RData,
    output logic              BReq,
    output logic [BUS_AW-1:0] AddrReq,
    output logic [1:0]        SizeReq,
    input  logic              BReqComplete,
    input  logic [BUS_DW-1:0] BData
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e        state, next_state;
    logic [CW-1:0]     starve_cnt;
    logic              lat_fetch;
    logic [BUS_AW-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic [BUS_DW-1:0] first_data;

    logic              fetch_wins;
    logic              grant;
    logic [BUS_AW-1:0] calc_addr;
    logic [1:0]        calc_size;

    logic              split;
    logic [1:0]        size1;
    logic [BUS_AW-1:0] addr2;
    logic [1:0]        size2;
    logic [4:0]        shift2;
    logic [BUS_DW-1:0] mask_n;
    logic [BUS_DW-1:0] mask_n2;

    assign fetch_wins = FReq & (~DReq | (starve_cnt == LIMIT));
    assign grant      = (state == IDLE) & (DReq | FReq);

    // In IDLE the calculator sees the would-be winner so the first bus size is
    // registered together with the grant; afterwards it sees the latched request.
    assign calc_addr = (state == IDLE) ? (fetch_wins ? FAddr : DAddr) : lat_addr;
    assign calc_size = (state == IDLE) ? (fetch_wins ? FSize : DSize) : lat_size;

    bus_split_calc u_split (
        .addr    (calc_addr),
        .size    (calc_size),
        .split   (split),
        .size1   (size1),
        .addr2   (addr2),
        .size2   (size2),
        .shift2  (shift2),
        .mask_n  (mask_n),
        .mask_n2 (mask_n2)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (DReq || FReq) next_state = ISSUE1;
            ISSUE1:  next_state = WAIT1;
            WAIT1:   if (BReqComplete) next_state = split ? ISSUE2 : DONE;
            ISSUE2:  next_state = WAIT2;
            WAIT2:   if (BReqComplete) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            starve_cnt <= '0;
            lat_fetch  <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= '0;
            first_data <= '0;
            AddrReq    <= '0;
            SizeReq    <= '0;
            RData      <= '0;
        end else begin
            if (grant) begin
                lat_fetch <= fetch_wins;
                lat_addr  <= calc_addr;
                lat_size  <= calc_size;
                AddrReq   <= calc_addr;
                SizeReq   <= size1;
                // Only data grants that bypass a waiting fetch count toward starvation.
                if (fetch_wins || !FReq)
                    starve_cnt <= '0;
                else if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + CW'(1);
            end
            if (state == WAIT1 && BReqComplete) begin
                if (split) begin
                    first_data <= BData;
                    AddrReq    <= addr2;
                    SizeReq    <= size2;
                end else begin
                    RData <= BData & mask_n;
                end
            end
            // Big-endian merge: the lower-addressed bytes land in the upper part.
            if (state == WAIT2 && BReqComplete)
                RData <= (first_data << shift2) | (BData & mask_n2);
        end
    end

    assign BReq = (state == ISSUE1) | (state == ISSUE2);
    assign DAck = (state == DONE) & ~lat_fetch;
    assign FAck = (state == DONE) &  lat_fetch;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// tb/tb_bus_req_arbiter.sv - self-checking bench for bus_req_arbiter
module tb_bus_req_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        DReq = 1'b0;
    logic [31:0] DAddr = '0;
    logic [1:0]  DSize = '0;
    logic        DAck;
    logic        FReq = 1'b0;
    logic [31:0] FAddr = '0;
    logic [1:0]  FSize = '0;
    logic        FAck;
    logic [31:0] RData;
    logic        BReq;
    logic [31:0] AddrReq;
    logic [1:0]  SizeReq;
    logic        BReqComplete = 1'b0;
    logic [31:0] BData = '0;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int last_cpl = -100;
    logic [31:0] bq_addr[$];
    logic [1:0]  bq_size[$];
    int          bq_cyc[$];
    logic [1:0]  rsp_size;

    bus_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .DReq(DReq), .DAddr(DAddr), .DSize(DSize), .DAck(DAck),
        .FReq(FReq), .FAddr(FAddr), .FSize(FSize), .FAck(FAck),
        .RData(RData), .BReq(BReq), .AddrReq(AddrReq), .SizeReq(SizeReq),
        .BReqComplete(BReqComplete), .BData(BData)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) ncyc <= ncyc + 1;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 4 : int'(s);
    endfunction

    function automatic logic [31:0] resp(input int n);
        return 32'h1122_3344 >> (8 * (4 - n));
    endfunction

    // Expected bus cycles and merged result, from byte counts and offsets.
    task automatic model_txn(input logic [31:0] addr, input logic [1:0] size, output int en,
                             output logic [31:0] a0, output logic [1:0] s0,
                             output logic [31:0] a1, output logic [1:0] s1,
                             output logic [31:0] rd);
        int n, o, n1, n2;
        n  = nbytes(size);
        o  = int'(addr % 4);
        a0 = addr;
        if (o + n <= 4) begin
            en = 1; s0 = size; a1 = '0; s1 = '0; rd = resp(n);
        end else begin
            n1 = 4 - o;
            n2 = n - n1;
            en = 2;
            s0 = 2'(n1 % 4);
            a1 = addr - 32'(o) + 32'd4;
            s1 = 2'(n2);
            rd = (resp(n1) << (8 * n2)) | resp(n2);
        end
    endtask

    // Bus controller: completes each cycle three clocks after BReq.
    initial begin
        forever begin
            @(negedge CLK);
            BReqComplete = 1'b0;
            BData = $urandom;
            if (BReq === 1'b1) begin
                rsp_size = SizeReq;
                bq_addr.push_back(AddrReq);
                bq_size.push_back(SizeReq);
                bq_cyc.push_back(ncyc);
                repeat (2) @(negedge CLK);
                BData = resp(nbytes(rsp_size));
                BReqComplete = 1'b1;
                last_cpl = ncyc;
            end
        end
    end

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if (DAck || FAck) got = 1'b1;
        end
    endtask

    task automatic run_txn(input bit fetch, input logic [31:0] addr, input logic [1:0] size);
        int en, start, prev;
        logic [31:0] a0, a1, erd;
        logic [1:0]  s0, s1;
        bit done, scr;
        model_txn(addr, size, en, a0, s0, a1, s1, erd);
        bq_addr.delete(); bq_size.delete(); bq_cyc.delete();
        prev = last_cpl;
        start = ncyc;
        if (fetch) begin FReq = 1'b1; FAddr = addr; FSize = size; end
        else       begin DReq = 1'b1; DAddr = addr; DSize = size; end
        done = 1'b0; scr = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (BReq && !scr) begin
                scr = 1'b1;
                if (fetch) begin FAddr = $urandom; FSize = 2'($urandom); end
                else       begin DAddr = $urandom; DSize = 2'($urandom); end
            end
            if (DAck || FAck) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL txn_timeout: got no ack want ack addr=%h", addr);
        end else begin
            checks++;
            if ({DAck, FAck} !== (fetch ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL ack_sel: got %b want %b", {DAck, FAck}, fetch ? 2'b01 : 2'b10);
            end
            checks++;
            if (RData !== erd) begin
                failures++;
                $display("FAIL rdata: got %h want %h (addr=%h size=%b)", RData, erd, addr, size);
            end
            checks++;
            if (bq_addr.size() != en) begin
                failures++;
                $display("FAIL bus_cycles: got %0d want %0d", bq_addr.size(), en);
            end
            for (int i = 0; i < en && i < bq_addr.size(); i++) begin
                checks++;
                if (bq_addr[i] !== (i == 0 ? a0 : a1) || bq_size[i] !== (i == 0 ? s0 : s1)) begin
                    failures++;
                    $display("FAIL bus_req%0d: got %h/%b want %h/%b", i, bq_addr[i], bq_size[i],
                             i == 0 ? a0 : a1, i == 0 ? s0 : s1);
                end
            end
            if (bq_cyc.size() > 0) begin
                checks++;
                if (bq_cyc[0] !== start + 1) begin
                    failures++;
                    $display("FAIL breq_latency: got %0d want %0d", bq_cyc[0] - start, 1);
                end
                checks++;
                if (bq_cyc[0] - prev < 2) begin
                    failures++;
                    $display("FAIL idle_gap: got %0d want >=2", bq_cyc[0] - prev);
                end
            end
            checks++;
            if (ncyc !== last_cpl + 1) begin
                failures++;
                $display("FAIL ack_latency: got %0d want %0d", ncyc - last_cpl, 1);
            end
        end
        DReq = 1'b0; FReq = 1'b0;
        @(negedge CLK);
        checks++;
        if ((DAck | FAck) !== 1'b0) begin
            failures++;
            $display("FAIL ack_pulse: got %b want 0", DAck | FAck);
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0; DReq = 1'b1; DAddr = 32'h100; DSize = 2'b00;
        repeat (3) @(negedge CLK);
        checks++;
        if ({BReq, DAck, FAck, AddrReq, SizeReq, RData} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got breq=%b dack=%b fack=%b addr=%h size=%b rdata=%h want all 0",
                     BReq, DAck, FAck, AddrReq, SizeReq, RData);
        end
        DReq = 1'b0;
        nRESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_aligned();
        run_txn(1'b0, 32'h0000_0100, 2'b00);
        checks++;
        if (bq_addr.size() != 1 || bq_addr[0] !== 32'h100 || bq_size[0] !== 2'b00 || RData !== 32'h1122_3344) begin
            failures++;
            $display("FAIL aligned: got n=%0d rdata=%h want n=1 100/00 rdata=11223344", bq_addr.size(), RData);
        end
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 32'h0000_0102, 2'b00);
        checks++;
        if (bq_addr.size() != 2 || bq_addr[0] !== 32'h102 || bq_size[0] !== 2'b10 ||
            bq_addr[1] !== 32'h104 || bq_size[1] !== 2'b10 || RData !== 32'h1122_1122) begin
            failures++;
            $display("FAIL misaligned: got n=%0d rdata=%h want 102/10,104/10 rdata=11221122", bq_addr.size(), RData);
        end
    endtask

    task automatic test_wrap();
        run_txn(1'b0, 32'hFFFF_FFFF, 2'b10);
        checks++;
        if (bq_addr.size() != 2 || bq_addr[1] !== 32'h0 || bq_size[1] !== 2'b01) begin
            failures++;
            $display("FAIL wrap: got n=%0d second=%h/%b want 00000000/01", bq_addr.size(), bq_addr[1], bq_size[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
    endtask

    task automatic test_simultaneous();
        logic [31:0] da, fa, a0, a1, erd;
        logic [1:0]  ds, fs, s0, s1;
        int en;
        bit got;
        da = $urandom; ds = 2'($urandom); fa = $urandom; fs = 2'($urandom);
        DAddr = da; DSize = ds; FAddr = fa; FSize = fs;
        DReq = 1'b1; FReq = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL simul_timeout: got no ack want ack %0d", k);
            end else begin
                checks++;
                if ({DAck, FAck} !== (k == 0 ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL simul_order%0d: got %b want %b", k, {DAck, FAck}, k == 0 ? 2'b10 : 2'b01);
                end
                if (k == 0) model_txn(da, ds, en, a0, s0, a1, s1, erd);
                else        model_txn(fa, fs, en, a0, s0, a1, s1, erd);
                checks++;
                if (RData !== erd) begin
                    failures++;
                    $display("FAIL simul_rdata%0d: got %h want %h", k, RData, erd);
                end
            end
            if (k == 0) DReq = 1'b0;
            else        FReq = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic test_starvation();
        logic [31:0] da, fa, a0, a1, erd;
        logic [1:0]  ds, fs, s0, s1;
        int en, data_run;
        bit got, fetch_done, exp_f;
        da = $urandom; ds = 2'($urandom); fa = $urandom; fs = 2'($urandom);
        DAddr = da; DSize = ds; FAddr = fa; FSize = fs;
        DReq = 1'b1; FReq = 1'b1;
        data_run = 0; fetch_done = 1'b0;
        for (int g = 0; g < LIMIT + 2 && !fetch_done; g++) begin
            wait_ack(got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL starve_timeout: got no ack want ack grant=%0d", g);
                fetch_done = 1'b1;
            end else begin
                exp_f = (data_run == LIMIT);
                checks++;
                if ({DAck, FAck} !== (exp_f ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL starve_order%0d: got %b want %b", g, {DAck, FAck}, exp_f ? 2'b01 : 2'b10);
                end
                if (FAck) model_txn(fa, fs, en, a0, s0, a1, s1, erd);
                else      model_txn(da, ds, en, a0, s0, a1, s1, erd);
                checks++;
                if (RData !== erd) begin
                    failures++;
                    $display("FAIL starve_rdata%0d: got %h want %h", g, RData, erd);
                end
                if (FAck) begin
                    fetch_done = 1'b1; FReq = 1'b0; DReq = 1'b0;
                end else begin
                    data_run++;
                    da = $urandom; ds = 2'($urandom);
                    DAddr = da; DSize = ds;
                end
            end
        end
        checks++;
        if (data_run !== LIMIT) begin
            failures++;
            $display("FAIL starve_count: got %0d want %0d", data_run, LIMIT);
        end
        DReq = 1'b0; FReq = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit seen, bad;
        DAddr = 32'h0000_0203; DSize = 2'b00; DReq = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (BReq && AddrReq == 32'h204) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_second_breq: got none want 00000204");
        end
        @(negedge CLK);
        #1 nRESET = 1'b0; DReq = 1'b0;
        #1;
        checks++;
        if ({BReq, DAck, FAck, AddrReq, SizeReq, RData} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got breq=%b dack=%b fack=%b addr=%h size=%b rdata=%h want all 0",
                     BReq, DAck, FAck, AddrReq, SizeReq, RData);
        end
        @(negedge CLK);
        #1 nRESET = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DAck || FAck || BReq) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mid_abandon: got ack/breq after reset want none");
        end
        run_txn(1'b0, 32'h0000_0203, 2'b00);
        checks++;
        if (RData !== 32'h1111_2233) begin
            failures++;
            $display("FAIL mid_recover: got %h want 11112233", RData);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_wrap();
        test_random();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
